// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick link (master and responder).
package joy_db15_pkg;

   localparam int PLAYER_BITS = 12;
   localparam int FRAME_BITS  = 2 * PLAYER_BITS;
   localparam int CNT_W       = 5;

   // Button bit positions inside a player word, layout FEDCBAUDLR.
   localparam int BTN_R  = 0;
   localparam int BTN_L  = 1;
   localparam int BTN_DN = 2;
   localparam int BTN_UP = 3;
   localparam int BTN_A  = 4;
   localparam int BTN_B  = 5;
   localparam int BTN_C  = 6;
   localparam int BTN_D  = 7;
   localparam int BTN_E  = 8;
   localparam int BTN_F  = 9;

   typedef logic [PLAYER_BITS-1:0] player_word_t;
   typedef logic [FRAME_BITS-1:0]  frame_t;

   // Frame in wire order: player 1 leaves first, bit 0 first; pins are active-low.
   function automatic frame_t wire_frame(player_word_t j1, player_word_t j2);
      return ~{j2, j1};
   endfunction

endpackage

// File: rtl/joy_db15_responder_if.sv
// Pin-level and button-level signals of the DB15 responder.
interface joy_db15_responder_if;
   import joy_db15_pkg::*;

   logic                 joy_clk_in;
   logic                 joy_load_in;
   player_word_t         joystick1;
   player_word_t         joystick2;
   logic                 joy_data_out;
   logic                 frame_done;
   logic [CNT_W-1:0]     bit_cnt;

   // The side that drives the pins and supplies the buttons.
   modport master (
      output joy_clk_in, joy_load_in, joystick1, joystick2,
      input  joy_data_out, frame_done, bit_cnt
   );

   // The emulated adapter.
   modport slave (
      input  joy_clk_in, joy_load_in, joystick1, joystick2,
      output joy_data_out, frame_done, bit_cnt
   );

endinterface

// File: rtl/joy_db15_responder_sync_ff.sv
// Generic multi-flop synchronizer with a configurable reset value.
module sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/joy_db15_responder.sv
// DB15 adapter emulation: parallel capture of two player words while LOAD is
// low, serial shift-out on each rising JOY_CLK while LOAD is high.
module joy_db15_responder
   import joy_db15_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   joy_db15_responder_if.slave  bus
);

   logic             clk_s;
   logic             load_s;
   logic             clk_prev_q;
   logic             clk_rise;
   logic             shift_mode;
   frame_t           sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (bus.joy_clk_in),
      .q_o     (clk_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (bus.joy_load_in),
      .q_o     (load_s)
   );

   assign shift_mode = load_s;
   assign clk_rise   = clk_s & ~clk_prev_q;

   // Next-state: load level wins over any coincident clock edge.
   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (!shift_mode) begin
         sr_d  = wire_frame(bus.joystick1, bus.joystick2);
         cnt_d = '0;
      end else if (clk_rise) begin
         sr_d = {1'b1, sr_q[FRAME_BITS-1:1]};
         if (cnt_q < CNT_W'(FRAME_BITS)) begin
            cnt_d  = cnt_q + CNT_W'(1);
            done_d = (cnt_q == CNT_W'(FRAME_BITS - 1));
         end
      end
   end

   // Datapath registers; reset leaves the line idle-high.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sr_q       <= '1;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         clk_prev_q <= 1'b1;
      end else begin
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         clk_prev_q <= clk_s;
      end
   end

   assign bus.joy_data_out = sr_q[0];
   assign bus.frame_done   = done_q;
   assign bus.bit_cnt      = cnt_q;

endmodule

// File: tb/tb_joy_db15_responder.sv
// Scoreboard bench for joy_db15_responder.
module tb_joy_db15_responder;
   import joy_db15_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   joy_db15_responder_if bus();

   joy_db15_responder #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   localparam int SEL_DATA  = 0;
   localparam int SEL_CNT   = 1;
   localparam int SEL_DONE  = 2;
   localparam int SEL_DCNT  = 3;

   typedef struct {
      string name;
      int    sel;
      int    exp;
   } exp_t;

   exp_t sb_q[$];
   event sample_ev;
   int   checks = 0;
   int   failures = 0;
   int   done_count = 0;

   task automatic expect_sig(input string name, input int sel, input int exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic present();
      -> sample_ev;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_bit(input string name, input int exp_d, input int exp_c);
      expect_sig({name, "_data"}, SEL_DATA, exp_d);
      expect_sig({name, "_cnt"}, SEL_CNT, exp_c);
      present();
   endtask

   task automatic do_load(input player_word_t a, input player_word_t b);
      bus.joystick1   = a;
      bus.joystick2   = b;
      bus.joy_load_in = 1'b0;
      cycles(5);
      bus.joy_load_in = 1'b1;
      cycles(5);
   endtask

   task automatic pulse();
      bus.joy_clk_in = 1'b1;
      cycles(5);
      bus.joy_clk_in = 1'b0;
      cycles(5);
   endtask

   // Reference: value on the data pin after k shifts of a frame loaded from j1/j2.
   function automatic int model_bit(input player_word_t j1, input player_word_t j2, input int k);
      if (k >= 24) return 1;
      if (k < 12)  return j1[k] ? 0 : 1;
      return j2[k-12] ? 0 : 1;
   endfunction

   // Monitor: drain the scoreboard whenever the stimulus presents a sample point.
   initial begin
      forever begin
         @(sample_ev);
         while (sb_q.size() > 0) begin
            exp_t e;
            int   act;
            e = sb_q.pop_front();
            case (e.sel)
               SEL_DATA: act = int'(bus.joy_data_out);
               SEL_CNT:  act = int'(bus.bit_cnt);
               SEL_DONE: act = int'(bus.frame_done);
               default:  act = done_count;
            endcase
            checks++;
            if (act != e.exp) begin
               failures++;
               $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
            end
         end
      end
   end

   // Frame-done monitor: count pulses and check they coincide with bit_cnt = 24.
   always @(posedge clk) begin
      if (reset_n && bus.frame_done) begin
         done_count++;
         checks++;
         if (bus.bit_cnt != 5'd24) begin
            failures++;
            $display("FAIL done_cnt_coincide: bit_cnt %0d expected 24", bus.bit_cnt);
         end
      end
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      player_word_t j1, j2;
      bus.joy_clk_in  = 1'b0;
      bus.joy_load_in = 1'b1;
      bus.joystick1   = '0;
      bus.joystick2   = '0;
      reset_n         = 1'b0;

      // Reset with pins toggling.
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         expect_sig($sformatf("rst%0d_data", i), SEL_DATA, 1);
         expect_sig($sformatf("rst%0d_cnt", i), SEL_CNT, 0);
         expect_sig($sformatf("rst%0d_done", i), SEL_DONE, 0);
         present();
         bus.joy_clk_in  = ~bus.joy_clk_in;
         bus.joy_load_in = ~bus.joy_load_in;
      end
      bus.joy_clk_in  = 1'b0;
      bus.joy_load_in = 1'b1;
      cycles(1);
      reset_n = 1'b1;
      cycles(4);

      // Full frame: stream 0, 22 ones, 0, then idle 1.
      do_load(12'h001, 12'h800);
      chk_bit("ff_pre", 0, 0);
      for (int k = 1; k <= 24; k++) begin
         pulse();
         chk_bit($sformatf("ff_k%0d", k), (k == 23) ? 0 : 1, k);
      end
      expect_sig("ff_done_count", SEL_DCNT, 1);
      present();

      // Over-clocking past the frame end.
      j1 = 12'hFFF; j2 = 12'h000;
      do_load(j1, j2);
      chk_bit("oc_pre", model_bit(j1, j2, 0), 0);
      for (int k = 1; k <= 28; k++) begin
         pulse();
         chk_bit($sformatf("oc_k%0d", k), model_bit(j1, j2, k), (k > 24) ? 24 : k);
      end
      expect_sig("oc_done_count", SEL_DCNT, 2);
      present();

      // Abort after 7 shifts.
      j1 = 12'h5A5; j2 = 12'h3C3;
      do_load(j1, j2);
      for (int k = 1; k <= 7; k++) pulse();
      chk_bit("ab_k7", model_bit(j1, j2, 7), 7);
      bus.joy_load_in = 1'b0;
      cycles(3);
      chk_bit("ab_reload", model_bit(j1, j2, 0), 0);
      cycles(3);
      bus.joy_load_in = 1'b1;
      cycles(5);
      chk_bit("ab_after", model_bit(j1, j2, 0), 0);
      expect_sig("ab_done_count", SEL_DCNT, 2);
      present();

      // Player-1 inputs change mid-frame; the frame in flight is unaffected.
      j1 = 12'h000; j2 = 12'h000;
      do_load(j1, j2);
      for (int k = 1; k <= 3; k++) pulse();
      bus.joystick1 = 12'hFFF;
      for (int k = 4; k <= 24; k++) begin
         pulse();
         chk_bit($sformatf("mc_k%0d", k), model_bit(j1, j2, k), k);
      end
      expect_sig("mc_done_count", SEL_DCNT, 3);
      present();

      // Latency: one rise appears on the pin exactly 3 clk cycles later.
      j1 = 12'h001; j2 = 12'h000;
      do_load(j1, j2);
      bus.joy_clk_in = 1'b1;
      cycles(1);
      chk_bit("lat_c1", 0, 0);
      cycles(1);
      chk_bit("lat_c2", 0, 0);
      cycles(1);
      chk_bit("lat_c3", 1, 1);
      cycles(2);
      bus.joy_clk_in = 1'b0;
      cycles(5);

      // One-cycle load glitch with new inputs: a clean reload, then normal shifting.
      j1 = 12'h003;
      bus.joystick1   = j1;
      bus.joy_load_in = 1'b0;
      cycles(1);
      bus.joy_load_in = 1'b1;
      cycles(5);
      chk_bit("gl_reload", model_bit(j1, j2, 0), 0);
      pulse();
      chk_bit("gl_k1", model_bit(j1, j2, 1), 1);
      expect_sig("gl_done_count", SEL_DCNT, 3);
      present();

      cycles(2);
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d entries left expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/joy_db15_responder.md
# joy_db15_responder

Emulates the DB15 adapter end of the UserIO joystick link: it plays the part of the adapter's chained parallel-in/serial-out shift registers. It captures two 12-bit player words when LOAD is low and shifts them out one bit per rising JOY_CLK. It sits in the loopback bench path and in the dual-board harness, facing the same JOY_CLK/JOY_LOAD/JOY_DATA pins that the joy_db15 master drives and samples.

## Interface
- FRAME_BITS, 24: bits per frame (2 players × 12); fixed by the adapter.
- SYNC_STAGES, 2: synchronizer depth on joy_clk_in and joy_load_in (≥2).
- clk  input  1  system clock (40–50 MHz, CLK_JOY domain).
- reset_n  input  1  reset, synchronous, active-low.
- joy_clk_in  input  1  shift clock from the master; asynchronous; rising edge shifts.
- joy_load_in  input  1  parallel load from the master; asynchronous; active-low, level-sensitive.
- joystick1  input  12  player 1 buttons, active-high, layout FEDCBAUDLR (bit 0 = R).
- joystick2  input  12  player 2 buttons, same layout.
- joy_data_out  output  1  serial data to the master; active-low (pressed = 0).
- frame_done  output  1  one-cycle pulse when the last frame bit has been shifted out.
- bit_cnt  output  5  number of shifts since the last load, saturating at FRAME_BITS.

## Operation
- Both pins pass through SYNC_STAGES flip-flops, then a one-flop edge detector. All logic after that uses only the synchronized copies.
- Shift register sr[23:0] holds the frame in wire order:
  - wire bit k = ~joystick1[k] for k = 0..11;
  - wire bit k = ~joystick2[k-12] for k = 12..23.
  - joy_data_out = wire bit at the current position.
- LOAD state (synchronized load = 0):
  - sr reloads from joystick1/joystick2 every cycle, so it is transparent.
  - bit_cnt = 0.
  - Clock edges are ignored.
- SHIFT state (synchronized load = 1):
  - On each synchronized joy_clk rising edge: sr shifts one position toward the output and a 1 enters the far end (serial input pulled high).
  - On each such edge, bit_cnt increments, saturating at FRAME_BITS.
- frame_done pulses on the edge that moves bit_cnt from FRAME_BITS-1 to FRAME_BITS.
- Edges beyond FRAME_BITS keep shifting 1s: joy_data_out = 1 and bit_cnt holds at 24. No second frame_done.
- A falling load during SHIFT aborts the frame immediately: reload and bit_cnt = 0. No frame_done.
- A clock edge and a load falling edge becoming visible in the same cycle: load wins.
- joystick inputs are sampled only during LOAD. Changes during SHIFT do not affect the frame in flight.

## Timing
- Reset (reset_n = 0 at a clk edge):
  - sr = all 1s, bit_cnt = 0, frame_done = 0, joy_data_out = 1;
  - synchronizers and the edge flop cleared to 1.
  - Mid-frame reset discards the frame.
- Pin-to-output latency: a joy_clk_in or joy_load_in change shows on joy_data_out after SYNC_STAGES+1 clk cycles (3 by default).
- Master constraints: joy_clk_in high and low each ≥ SYNC_STAGES+2 clk cycles, and the load pulse ≥ SYNC_STAGES+2 clk cycles.
- joy_data_out is registered (no combinational path from the pins).
- frame_done is registered and coincides with bit_cnt becoming 24.

## Structure
- Shared package joy_db15_pkg holds:
  - FRAME_BITS, PLAYER_BITS = 12;
  - button bit indices R, L, D, U, A–F;
  - a typedef for the 12-bit player word.
  - The joy_db15 master imports the same package.
- Sub-module sync_ff #(SYNC_STAGES): generic multi-flop synchronizer, instantiated once per pin.
- Top is one FSM-less datapath: a LOAD/SHIFT mode bit derived from synchronized load, plus sr, bit_cnt and the edge flop.

## Test plan
- Reset: hold reset_n = 0 for 4 cycles with pins toggling -> joy_data_out = 1, bit_cnt = 0, frame_done = 0 throughout.
- Full frame: joystick1 = 12'h001, joystick2 = 12'h800, load pulse, then 24 clocks -> serial stream 0, 1×22, 0; frame_done pulses once, coincident with bit_cnt becoming 24.
- Over-clocking: 28 clocks after load with joystick1 = 12'hFFF -> bits 0–11 = 0, then 1s; bit_cnt stays 24; exactly one frame_done.
- Abort: load asserted after 7 clocks -> bit_cnt = 0 within 3 cycles; joy_data_out = ~joystick1[0]; no frame_done.
- Input change mid-frame: joystick1 changes 12'h000 -> 12'hFFF after 3 clocks -> remaining player-1 bits still read 1 (original values).
- Latency/sync: single joy_clk_in rise -> joy_data_out changes exactly 3 clk cycles later; a 1-cycle glitch on load, shorter than the synchronizer window, is either fully taken (a proper reload) or fully ignored, with no partial shift.
